// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: memory response
// codes and the hold/fault FSM state encoding.
package pipe_hazard_ctrl_pkg;

    localparam int MEM_CODE_W_DEF = 2;

    // Memory response codes presented by the data memory each cycle.
    typedef enum logic [MEM_CODE_W_DEF-1:0] {
        MEM_NONE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_OK   = 2'd2,
        MEM_ERR  = 2'd3
    } mem_code_e;

    // Controller states: free running, holding on memory, dead on fault.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_FAULT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in decode is about to read. Register 0 never hazards.
module hazard_cmp #(
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic                 i_rs1_en,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic                 i_rs2_en,
    input  logic                 i_ex_load,
    input  logic [REG_IDX_W-1:0] i_ex_dest,
    output logic                 o_hazard
);

    logic dest_live;
    logic rs1_hit;
    logic rs2_hit;

    // Match each enabled source against a live (non-x0) load destination.
    always_comb begin
        dest_live = i_ex_load && (i_ex_dest != '0);
        rs1_hit   = i_rs1_en && (i_rs1 == i_ex_dest);
        rs2_hit   = i_rs2_en && (i_rs2 == i_ex_dest);
        o_hazard  = dest_live && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the in-order pipeline. Generates the
// per-stage hold and bubble masks, tracks memory waits with a timeout,
// defers redirects that land during a hold, latches memory faults and
// counts fetch-stall cycles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int N_STAGES    = 5,
    parameter int ID_STAGE    = 1,
    parameter int EX_STAGE    = 2,
    parameter int ME_STAGE    = 3,
    parameter int REG_IDX_W   = 5,
    parameter int MEM_CODE_W  = MEM_CODE_W_DEF,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [REG_IDX_W-1:0]  i_id_rs1,
    input  logic                  i_id_rs1_en,
    input  logic [REG_IDX_W-1:0]  i_id_rs2,
    input  logic                  i_id_rs2_en,
    input  logic                  i_ex_load,
    input  logic [REG_IDX_W-1:0]  i_ex_dest_reg,
    input  logic                  i_me_req,
    input  logic [MEM_CODE_W-1:0] i_mem_res_code,
    input  logic                  i_redirect,
    output logic [N_STAGES-1:0]   o_stall,
    output logic [N_STAGES-1:0]   o_clr,
    output logic                  o_fault,
    output logic                  o_fault_timeout,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    // Stage masks. Memory wait freezes fetch..ME and bubbles the stage after
    // ME; load-use freezes fetch..ID and bubbles EX; redirect squashes the
    // stages younger than EX.
    localparam logic [N_STAGES-1:0] ONE        = N_STAGES'(1);
    localparam logic [N_STAGES-1:0] WAIT_STALL = (ONE << (ME_STAGE + 1)) - ONE;
    localparam logic [N_STAGES-1:0] WAIT_CLR   = ONE << (ME_STAGE + 1);
    localparam logic [N_STAGES-1:0] LU_STALL   = (ONE << (ID_STAGE + 1)) - ONE;
    localparam logic [N_STAGES-1:0] LU_CLR     = ONE << EX_STAGE;
    localparam logic [N_STAGES-1:0] REDIR_CLR  = (ONE << EX_STAGE) - ONE;

    hz_state_e         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              pend_q, pend_d;
    logic              cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              load_use;
    logic              code_wait, code_ok, code_err;
    logic              mem_hold;
    logic [WCNT_W:0]   wcnt_inc;
    logic [N_STAGES-1:0] stall_int, clr_int;

    hazard_cmp #(.REG_IDX_W(REG_IDX_W)) u_hazard_cmp (
        .i_rs1     (i_id_rs1),
        .i_rs1_en  (i_id_rs1_en),
        .i_rs2     (i_id_rs2),
        .i_rs2_en  (i_id_rs2_en),
        .i_ex_load (i_ex_load),
        .i_ex_dest (i_ex_dest_reg),
        .o_hazard  (load_use)
    );

    // Decode the memory response; NONE while waiting counts as another WAIT.
    always_comb begin
        code_wait = (i_mem_res_code == MEM_CODE_W'(MEM_WAIT));
        code_ok   = (i_mem_res_code == MEM_CODE_W'(MEM_OK));
        code_err  = (i_mem_res_code == MEM_CODE_W'(MEM_ERR));
        mem_hold  = ((state_q == ST_MWAIT) && !code_ok) ||
                    ((state_q == ST_RUN) && i_me_req && code_wait);
        wcnt_inc  = {1'b0, wcnt_q} + 1'b1;
    end

    // Stall/clr masks by priority: fault, memory hold, redirect, load-use.
    // The MWAIT exit cycle (OK seen) behaves as RUN so deferred redirects and
    // fresh hazards both take effect there.
    always_comb begin
        stall_int = '0;
        clr_int   = '0;
        if (state_q == ST_FAULT) begin
            stall_int = '1;
        end else if (mem_hold) begin
            stall_int = WAIT_STALL;
            clr_int   = WAIT_CLR;
        end else if (i_redirect || pend_q) begin
            clr_int   = REDIR_CLR;
        end else if (load_use) begin
            stall_int = LU_STALL;
            clr_int   = LU_CLR;
        end
    end

    // Outputs are forced to the reset pattern while resetn is low.
    always_comb begin
        o_stall         = resetn ? stall_int : '0;
        o_clr           = resetn ? clr_int : '1;
        o_fault         = resetn && (state_q == ST_FAULT);
        o_fault_timeout = resetn && cause_q;
        o_stall_cnt     = resetn ? cnt_q : '0;
    end

    // Next state: FSM transitions, wait timeout, pending redirect, counter.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pend_d  = pend_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        if (stall_int[0] && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            ST_RUN: begin
                if (i_me_req && code_wait) begin
                    state_d = ST_MWAIT;
                    wcnt_d  = WCNT_W'(1);
                    pend_d  = i_redirect;
                end else if (i_me_req && code_err) begin
                    state_d = ST_FAULT;
                    cause_d = 1'b0;
                end
            end
            ST_MWAIT: begin
                if (code_ok) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                    pend_d  = 1'b0;
                end else if (code_err) begin
                    state_d = ST_FAULT;
                    cause_d = 1'b0;
                    pend_d  = 1'b0;
                end else if (wcnt_inc >= (WCNT_W + 1)'(MEM_TIMEOUT)) begin
                    state_d = ST_FAULT;
                    cause_d = 1'b1;
                    pend_d  = 1'b0;
                end else begin
                    wcnt_d = wcnt_inc[WCNT_W-1:0];
                    if (i_redirect) begin
                        pend_d = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                pend_d = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
            pend_q  <= 1'b0;
            cause_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pend_q  <= pend_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table of single-cycle vectors plus
// multi-cycle sequences; expectations queued at drive time and checked by a
// monitor on the falling edge. A second instance with CNT_W=4 checks
// counter saturation.
module tb_pipe_hazard_ctrl;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_WAIT = 2'd1;
    localparam logic [1:0] C_OK   = 2'd2;
    localparam logic [1:0] C_ERR  = 2'd3;

    localparam logic [4:0] W_S  = 5'b01111;
    localparam logic [4:0] W_C  = 5'b10000;
    localparam logic [4:0] LU_S = 5'b00011;
    localparam logic [4:0] LU_C = 5'b00100;
    localparam logic [4:0] R_C  = 5'b00011;
    localparam logic [4:0] ALL  = 5'b11111;

    typedef struct {
        logic       rstn;
        logic [4:0] rs1;
        logic       rs1_en;
        logic [4:0] rs2;
        logic       rs2_en;
        logic       ld;
        logic [4:0] dest;
        logic       me_req;
        logic [1:0] code;
        logic       redir;
        logic [4:0] stall;
        logic [4:0] clr;
        logic       fault;
        logic       cause;
    } vec_t;

    typedef struct {
        int          tag;
        logic [4:0]  stall;
        logic [4:0]  clr;
        logic        fault;
        logic        cause;
        logic [15:0] cnt;
        logic [3:0]  cnt_s;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, dest = '0;
    logic        rs1_en = 1'b0, rs2_en = 1'b0, ld = 1'b0, me_req = 1'b0, redir = 1'b0;
    logic [1:0]  code = '0;
    logic [4:0]  stall, clr, stall_s, clr_s;
    logic        fault, cause, fault_s, cause_s;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;

    pipe_hazard_ctrl dut (
        .clk(clk), .resetn(resetn),
        .i_id_rs1(rs1), .i_id_rs1_en(rs1_en), .i_id_rs2(rs2), .i_id_rs2_en(rs2_en),
        .i_ex_load(ld), .i_ex_dest_reg(dest), .i_me_req(me_req),
        .i_mem_res_code(code), .i_redirect(redir),
        .o_stall(stall), .o_clr(clr), .o_fault(fault),
        .o_fault_timeout(cause), .o_stall_cnt(cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .resetn(resetn),
        .i_id_rs1(rs1), .i_id_rs1_en(rs1_en), .i_id_rs2(rs2), .i_id_rs2_en(rs2_en),
        .i_ex_load(ld), .i_ex_dest_reg(dest), .i_me_req(me_req),
        .i_mem_res_code(code), .i_redirect(redir),
        .o_stall(stall_s), .o_clr(clr_s), .o_fault(fault_s),
        .o_fault_timeout(cause_s), .o_stall_cnt(cnt_s)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          vec_no = 0;
    logic [15:0] mcnt   = '0;
    logic [3:0]  mcnt_s = '0;

    function automatic vec_t mk(input logic rn, input logic [4:0] a, input logic ae,
                                input logic [4:0] b, input logic be, input logic l,
                                input logic [4:0] d, input logic mq, input logic [1:0] c,
                                input logic rd, input logic [4:0] es, input logic [4:0] ec,
                                input logic ef, input logic et);
        vec_t v;
        v.rstn = rn; v.rs1 = a; v.rs1_en = ae; v.rs2 = b; v.rs2_en = be;
        v.ld = l; v.dest = d; v.me_req = mq; v.code = c; v.redir = rd;
        v.stall = es; v.clr = ec; v.fault = ef; v.cause = et;
        return v;
    endfunction

    function automatic vec_t rst();
        return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, C_NONE, 1'b0, 5'd0, ALL, 1'b0, 1'b0);
    endfunction

    function automatic vec_t idle(input logic [4:0] es, input logic [4:0] ec,
                                  input logic ef, input logic et);
        return mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, C_NONE, 1'b0, es, ec, ef, et);
    endfunction

    function automatic vec_t mem(input logic [1:0] c, input logic rd, input logic [4:0] es,
                                 input logic [4:0] ec, input logic ef, input logic et);
        return mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, c, rd, es, ec, ef, et);
    endfunction

    task automatic chk(input string nm, input int tag, input logic [15:0] act,
                       input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, tag, act, expv);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show this cycle.
    task automatic step(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        resetn = v.rstn; rs1 = v.rs1; rs1_en = v.rs1_en; rs2 = v.rs2; rs2_en = v.rs2_en;
        ld = v.ld; dest = v.dest; me_req = v.me_req; code = v.code; redir = v.redir;
        e.tag = vec_no; e.stall = v.stall; e.clr = v.clr; e.fault = v.fault; e.cause = v.cause;
        e.cnt = v.rstn ? mcnt : 16'd0;
        e.cnt_s = v.rstn ? mcnt_s : 4'd0;
        exp_q.push_back(e);
        vec_no++;
        if (!v.rstn) begin
            mcnt = '0;
            mcnt_s = '0;
        end else if (v.stall[0]) begin
            if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            if (mcnt_s != 4'hF) mcnt_s = mcnt_s + 4'd1;
        end
    endtask

    // Monitor: compare outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", e.tag, {11'd0, stall}, {11'd0, e.stall});
            chk("clr", e.tag, {11'd0, clr}, {11'd0, e.clr});
            chk("fault", e.tag, {15'd0, fault}, {15'd0, e.fault});
            chk("fault_timeout", e.tag, {15'd0, cause}, {15'd0, e.cause});
            chk("stall_cnt", e.tag, cnt, e.cnt);
            chk("stall_cnt_sat", e.tag, {12'd0, cnt_s}, {12'd0, e.cnt_s});
            chk("fault_sat", e.tag, {15'd0, fault_s}, {15'd0, e.fault});
        end
    end

    vec_t tbl[$];

    initial begin
        // Single-cycle vectors, each starting from RUN.
        tbl.push_back(rst());
        tbl.push_back(rst());
        tbl.push_back(idle(5'd0, 5'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1, 5'd0, 0, 5'd5, 1, 1, 5'd5, 0, C_NONE, 0, LU_S, LU_C, 0, 0));
        tbl.push_back(idle(5'd0, 5'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1, 5'd0, 0, 5'd0, 1, 1, 5'd0, 0, C_NONE, 0, 5'd0, 5'd0, 0, 0));
        tbl.push_back(mk(1, 5'd7, 1, 5'd3, 1, 1, 5'd7, 0, C_NONE, 0, LU_S, LU_C, 0, 0));
        tbl.push_back(mk(1, 5'd7, 0, 5'd3, 1, 1, 5'd7, 0, C_NONE, 0, 5'd0, 5'd0, 0, 0));
        tbl.push_back(mk(1, 5'd3, 1, 5'd9, 0, 1, 5'd9, 0, C_NONE, 0, 5'd0, 5'd0, 0, 0));
        tbl.push_back(mk(1, 5'd9, 1, 5'd9, 1, 0, 5'd9, 0, C_NONE, 0, 5'd0, 5'd0, 0, 0));
        tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, C_NONE, 1, 5'd0, R_C, 0, 0));
        tbl.push_back(mk(1, 5'd4, 1, 5'd0, 0, 1, 5'd4, 0, C_NONE, 1, 5'd0, R_C, 0, 0));
        tbl.push_back(mem(C_OK, 0, 5'd0, 5'd0, 0, 0));
        tbl.push_back(mk(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, C_WAIT, 0, 5'd0, 5'd0, 0, 0));
        tbl.push_back(mem(C_NONE, 0, 5'd0, 5'd0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Memory wait of 3 cycles (first one with a load-use present), then OK.
        step(rst());
        step(mk(1, 5'd6, 1, 5'd0, 0, 1, 5'd6, 1, C_WAIT, 0, W_S, W_C, 0, 0));
        step(mem(C_WAIT, 0, W_S, W_C, 0, 0));
        step(mem(C_WAIT, 0, W_S, W_C, 0, 0));
        step(mem(C_OK, 0, 5'd0, 5'd0, 0, 0));
        step(idle(5'd0, 5'd0, 0, 0));

        // NONE while waiting keeps the hold.
        step(rst());
        step(mem(C_WAIT, 0, W_S, W_C, 0, 0));
        step(mem(C_NONE, 0, W_S, W_C, 0, 0));
        step(mem(C_OK, 0, 5'd0, 5'd0, 0, 0));
        step(idle(5'd0, 5'd0, 0, 0));

        // Redirect on 2nd WAIT cycle is deferred to the OK cycle.
        step(rst());
        step(mem(C_WAIT, 0, W_S, W_C, 0, 0));
        step(mem(C_WAIT, 1, W_S, W_C, 0, 0));
        step(mem(C_WAIT, 0, W_S, W_C, 0, 0));
        step(mem(C_OK, 0, 5'd0, R_C, 0, 0));
        step(idle(5'd0, 5'd0, 0, 0));

        // Redirect on the RUN->MWAIT cycle is deferred too.
        step(rst());
        step(mem(C_WAIT, 1, W_S, W_C, 0, 0));
        step(mem(C_OK, 0, 5'd0, R_C, 0, 0));
        step(idle(5'd0, 5'd0, 0, 0));

        // ERR during a wait faults and drops the pending redirect.
        step(rst());
        step(mem(C_WAIT, 1, W_S, W_C, 0, 0));
        step(mem(C_ERR, 0, W_S, W_C, 0, 0));
        step(idle(ALL, 5'd0, 1, 0));
        step(mem(C_OK, 1, ALL, 5'd0, 1, 0));

        // Timeout: fault visible after the 15th consecutive WAIT.
        step(rst());
        for (int i = 1; i <= 20; i++) begin
            if (i <= 15) step(mem(C_WAIT, 0, W_S, W_C, 0, 0));
            else         step(mem(C_WAIT, 0, ALL, 5'd0, 1, 1));
        end
        step(mem(C_OK, 0, ALL, 5'd0, 1, 1));
        step(rst());
        step(idle(5'd0, 5'd0, 0, 0));

        // ERR in RUN, then hold the fault long enough to saturate the 4-bit counter.
        step(rst());
        step(idle(5'd0, 5'd0, 0, 0));
        step(mem(C_ERR, 0, 5'd0, 5'd0, 0, 0));
        for (int i = 0; i < 20; i++) step(idle(ALL, 5'd0, 1, 0));
        step(rst());
        step(idle(5'd0, 5'd0, 0, 0));

        // Let the monitor drain the queue, bounded.
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the N-stage in-order pipeline. Replaces the per-stage stall/clr tie-offs at the pipeline top.
- Detects load-use hazards, holds the pipeline while a memory request is outstanding, and bubbles/flushes on PC redirect. A redirect that arrives during a hold is kept pending until the hold ends.
- Latches unrecoverable memory faults and counts stall cycles.
- Stage index 0 = fetch, rising toward writeback.

Parameters:
- N_STAGES, 5, number of pipeline stages (min 4).
- ID_STAGE, 1, index of decode stage.
- EX_STAGE, 2, index of execute stage.
- ME_STAGE, 3, index of memory stage; must be < N_STAGES-1.
- REG_IDX_W, 5, register index width.
- MEM_CODE_W, 2, memory response code width.
- MEM_TIMEOUT, 15, maximum consecutive WAIT cycles tolerated.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- i_id_rs1  in  REG_IDX_W  decode source 1 index
- i_id_rs1_en  in  1  decode reads rs1
- i_id_rs2  in  REG_IDX_W  decode source 2 index
- i_id_rs2_en  in  1  decode reads rs2
- i_ex_load  in  1  EX holds a valid load
- i_ex_dest_reg  in  REG_IDX_W  EX destination index
- i_me_req  in  1  ME holds a valid memory access
- i_mem_res_code  in  MEM_CODE_W  memory response code
- i_redirect  in  1  EX branch/jump taken (one-cycle pulse)
- o_stall  out  N_STAGES  per-stage hold
- o_clr  out  N_STAGES  per-stage bubble insert
- o_fault  out  1  sticky memory fault
- o_fault_timeout  out  1  fault cause: 1 = timeout, 0 = error code
- o_stall_cnt  out  CNT_W  saturating count of cycles with o_stall[0]=1

Behaviour:
- Reset: clk and resetn as stated; reset is synchronous and active-low.
  - While resetn=0: o_clr all ones, o_stall 0, o_fault 0, o_fault_timeout 0, o_stall_cnt 0.
  - Also while resetn=0: state RUN, pending-redirect flag 0, wait counter 0.
- Timing: o_stall/o_clr are combinational from registered state and current inputs, so there is zero-cycle response. All state updates on the rising edge of clk.
- Memory codes: 0 NONE, 1 WAIT, 2 OK, 3 ERR.
- FSM states:
  - RUN: normal operation.
    - i_me_req=1 and code=WAIT: go to MWAIT; wait counter=1.
    - i_me_req=1 and code=ERR: go to FAULT, cause=0.
  - MWAIT:
    - o_stall[0..ME_STAGE]=1, o_clr[ME_STAGE+1]=1 (bubble into the stages after ME); all other bits 0.
    - code=OK: return to RUN. The stall is deasserted in that same cycle.
    - code=ERR: go to FAULT, cause=0.
    - code=WAIT: increment the wait counter. If the counter has reached MEM_TIMEOUT, go to FAULT with cause=1.
    - code=NONE while in MWAIT is treated as WAIT.
  - FAULT: o_stall all ones, o_clr 0, o_fault=1. Exited only by reset.
- Combinational stall in RUN: when i_me_req=1 and code=WAIT, the MWAIT stall/clr pattern applies in that same cycle.
- Load-use hazard (RUN only, no memory wait):
  - Condition: i_ex_load=1, i_ex_dest_reg!=0, and it matches rs1 (when rs1_en) or rs2 (when rs2_en).
  - Response: o_stall[0..ID_STAGE]=1, o_clr[EX_STAGE]=1.
  - Lasts exactly one cycle, because the load advances.
- Redirect (RUN, no memory wait): o_clr[0..EX_STAGE-1]=1, o_stall 0.
  - Redirect overrides a simultaneous load-use hazard; the stale decode instruction is squashed.
- Redirect during MWAIT or on the RUN→MWAIT cycle:
  - Set the pending flag.
  - On the cycle MWAIT exits to RUN, apply the redirect clr pattern and clear the flag.
  - FAULT discards the pending flag.
- Priority: FAULT > memory wait > redirect/pending > load-use.
- Register 0 never causes a hazard.
- o_stall_cnt: increments on every cycle with o_stall[0]=1, including FAULT. It saturates at all ones.

Decomposition:
- Shared header (mem_codes.vh): memory response code constants (NONE/WAIT/OK/ERR) and MEM_CODE_W.
- Same header: FSM state encoding (RUN/MWAIT/FAULT).
- Natural sub-module: hazard_cmp. It is a combinational load-use comparator with REG_IDX_W parameter and outputs the hazard flag.
- FSM, counters and stall/clr mask generation stay in the top.

Test Plan:
- Reset: hold resetn=0 for 2 cycles → o_clr=5'b11111, o_stall=0, o_stall_cnt=0. Release → o_clr=0.
- Load-use: i_ex_load=1, ex_dest=5, id_rs2=5 with rs2_en=1 → o_stall=5'b00011, o_clr=5'b00100 for 1 cycle.
  - Same stimulus with dest=0 → no stall.
- Memory wait: WAIT for 3 cycles, then OK → o_stall=5'b01111, o_clr=5'b10000 for 3 cycles, then 0. o_stall_cnt=3.
- Redirect in wait: redirect pulse on the 2nd WAIT cycle, OK on the 4th → on the OK cycle o_stall=0 and o_clr=5'b00011, then 0.
- Timeout: WAIT held 20 cycles → o_fault=1 after the 15th WAIT cycle, o_fault_timeout=1, o_stall=5'b11111 until reset.
- Error and saturation: ERR in RUN → o_fault=1, cause=0. With CNT_W=4 and fault held 20 cycles → o_stall_cnt=15.
